// File: rtl/uart_pkg.sv
// Shared UART definitions: flow-control byte values and the receiver FSM states.
package uart_pkg;

    localparam logic [7:0] XON  = 8'h11;
    localparam logic [7:0] XOFF = 8'h13;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit, with a
// selectable reset level so an idle-high line does not look active after reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_in,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // capture the pre-edge values and the chain really is two stages deep.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            meta <= RST_VAL;
            q_o  <= RST_VAL;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-bit glitch rejection, framing-error pulse
// and an XON/XOFF-driven pause flag for the local transmitter.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_in,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       stb_o,
    output logic       frame_err_o,
    output logic       xoff_o
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);

    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             stb_q, stb_d;
    logic             ferr_q, ferr_d;
    logic             xoff_q, xoff_d;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_in(rst_in),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            stb_q     <= 1'b0;
            ferr_q    <= 1'b0;
            xoff_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            stb_q     <= stb_d;
            ferr_q    <= ferr_d;
            xoff_q    <= xoff_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        stb_d     = 1'b0;
        ferr_d    = 1'b0;
        xoff_d    = xoff_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end

            START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                // Leaving at mid stop bit lets a back-to-back start bit be seen.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        stb_d   = 1'b1;
                        state_d = IDLE;
                        if (shift_q == XOFF) begin
                            xoff_d = 1'b1;
                        end else if (shift_q == XON) begin
                            xoff_d = 1'b0;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_o      = data_q;
    assign stb_o       = stb_q;
    assign frame_err_o = ferr_q;
    assign xoff_o      = xoff_q;

endmodule
